fir_tap_accumulator: RTL and testbench



---
 rtl/fir_tap_accumulator_pkg.sv | 37 +++
 rtl/fir_tap_accumulator_if.sv | 16 +
 rtl/fir_out_fifo2.sv | 77 +++++++
 rtl/fir_tap_accumulator.sv | 99 +++++++++
 tb/tb_fir_tap_accumulator.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fir_tap_accumulator_pkg.sv
// Shared constants for the coefficient multiplier and the tap accumulator,
// plus the round/scale/saturate helper applied to every finished tap sum.
package fir_pkg;

   localparam int PROD_WIDTH     = 34;
   localparam int OUT_DATA_WIDTH = 21;
   localparam int SHIFT          = 16;
   localparam int NUM_TAPS       = 16;

   typedef struct packed {
      logic                      sat;
      logic [OUT_DATA_WIDTH-1:0] data;
   } sat_res_t;

   // Round half toward +inf, drop 'shift' fraction bits, clamp to the output range.
   function automatic sat_res_t sat_round(input logic signed [63:0] sum,
                                          input int unsigned        shift);
      logic signed [63:0] r;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      sat_res_t           res;
      r     = (sum + (64'sd1 <<< (shift - 1))) >>> shift;
      max_v = (64'sd1 <<< (OUT_DATA_WIDTH - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (OUT_DATA_WIDTH - 1));
      res.sat  = 1'b0;
      res.data = r[OUT_DATA_WIDTH-1:0];
      if (r > max_v) begin
         res.sat  = 1'b1;
         res.data = max_v[OUT_DATA_WIDTH-1:0];
      end else if (r < min_v) begin
         res.sat  = 1'b1;
         res.data = min_v[OUT_DATA_WIDTH-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_tap_accumulator_if.sv
// Product input stream and valid/ready sample output of the tap accumulator.
interface fir_tap_accumulator_if #(
   parameter int PROD_WIDTH     = fir_pkg::PROD_WIDTH,
   parameter int OUT_DATA_WIDTH = fir_pkg::OUT_DATA_WIDTH
);
   logic signed [PROD_WIDTH-1:0]     prod_data;
   logic                             prod_vld;
   logic signed [OUT_DATA_WIDTH-1:0] out_data;
   logic                             out_vld;
   logic                             out_rdy;

   modport master (output prod_data, prod_vld, out_rdy,
                   input  out_data, out_vld);
   modport slave  (input  prod_data, prod_vld, out_rdy,
                   output out_data, out_vld);
endinterface

// File: rtl/fir_out_fifo2.sv
// Two-entry register FIFO; the head is a register so data_o is glitch-free.
// A push while full without a simultaneous pop is dropped and flagged.
module fir_out_fifo2 #(
   parameter int W = 21
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   output logic         full_o,
   input  logic         pop_i,
   output logic         empty_o,
   output logic [W-1:0] data_o,
   output logic         drop_o
);
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         pop;

   assign empty_o = (cnt_q == 2'd0);
   assign full_o  = (cnt_q == 2'd2);
   assign data_o  = head_q;
   assign pop     = pop_i && !empty_o;
   assign drop_o  = push_i && full_o && !pop_i && !clr_i;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = 2'd0;
      end else begin
         case (cnt_q)
            2'd0: if (push_i) begin
               head_d = data_i;
               cnt_d  = 2'd1;
            end
            2'd1: begin
               if (push_i && pop) begin
                  head_d = data_i;
               end else if (pop) begin
                  head_d = '0;
                  cnt_d  = 2'd0;
               end else if (push_i) begin
                  tail_d = data_i;
                  cnt_d  = 2'd2;
               end
            end
            default: if (pop) begin
               head_d = tail_q;
               if (push_i) begin
                  tail_d = data_i;
               end else begin
                  tail_d = '0;
                  cnt_d  = 2'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/fir_tap_accumulator.sv
// Sums NUM_TAPS consecutive multiplier products into one FIR sample, then
// rounds/saturates it into a two-entry output buffer (drop-on-full).
module fir_tap_accumulator #(
   parameter int NUM_TAPS   = fir_pkg::NUM_TAPS,
   parameter int PROD_WIDTH = fir_pkg::PROD_WIDTH,
   parameter int SHIFT      = fir_pkg::SHIFT
) (
   input  logic                      clk,
   input  logic                      reset_n,
   fir_tap_accumulator_if.slave      bus,
   input  logic                      clr,
   output logic                      sat_seen,
   output logic                      overrun
);
   import fir_pkg::*;

   localparam int CW        = $clog2(NUM_TAPS);
   localparam int ACC_WIDTH = PROD_WIDTH + CW;

   logic [CW-1:0]        tap_cnt_q, tap_cnt_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] sum_q, sum_d;
   logic                 sum_vld_q, sum_vld_d;
   logic                 sat_seen_q, sat_seen_d;
   logic                 overrun_q, overrun_d;

   logic [ACC_WIDTH-1:0] sext;
   logic [ACC_WIDTH-1:0] acc_sum;
   logic                 last_tap;
   logic [63:0]          sum64;
   sat_res_t             rnd;
   logic                 fifo_drop;
   logic                 fifo_empty;
   logic                 fifo_full_unused;

   assign sext     = {{CW{bus.prod_data[PROD_WIDTH-1]}}, bus.prod_data};
   assign last_tap = (tap_cnt_q == CW'(NUM_TAPS - 1));
   assign acc_sum  = (tap_cnt_q == '0) ? sext : acc_q + sext;
   assign sum64    = {{(64 - ACC_WIDTH){sum_q[ACC_WIDTH-1]}}, sum_q};
   assign rnd      = sat_round(sum64, 32'(SHIFT));

   always_comb begin
      tap_cnt_d  = tap_cnt_q;
      acc_d      = acc_q;
      sum_d      = sum_q;
      sum_vld_d  = 1'b0;
      sat_seen_d = sat_seen_q | (sum_vld_q & rnd.sat);
      overrun_d  = overrun_q | fifo_drop;
      if (clr) begin
         tap_cnt_d  = '0;
         acc_d      = '0;
         sum_d      = '0;
         sat_seen_d = 1'b0;
         overrun_d  = 1'b0;
      end else if (bus.prod_vld) begin
         acc_d     = acc_sum;
         tap_cnt_d = last_tap ? '0 : tap_cnt_q + 1'b1;
         if (last_tap) begin
            sum_d     = acc_sum;
            sum_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tap_cnt_q  <= '0;
         acc_q      <= '0;
         sum_q      <= '0;
         sum_vld_q  <= 1'b0;
         sat_seen_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         tap_cnt_q  <= tap_cnt_d;
         acc_q      <= acc_d;
         sum_q      <= sum_d;
         sum_vld_q  <= sum_vld_d;
         sat_seen_q <= sat_seen_d;
         overrun_q  <= overrun_d;
      end
   end

   fir_out_fifo2 #(.W(OUT_DATA_WIDTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (clr),
      .push_i  (sum_vld_q),
      .data_i  (rnd.data),
      .full_o  (fifo_full_unused),
      .pop_i   (bus.out_rdy),
      .empty_o (fifo_empty),
      .data_o  (bus.out_data),
      .drop_o  (fifo_drop)
   );

   assign bus.out_vld = !fifo_empty;
   assign sat_seen    = sat_seen_q;
   assign overrun     = overrun_q;
endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Directed bench: two accumulators (SHIFT 16 and SHIFT 8, four taps each);
// expected samples are queued at stimulus time and popped by per-DUT monitors.
module tb_fir_tap_accumulator;
   localparam int PW = 34;
   localparam int OW = 21;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clr16 = 1'b0;
   logic clr8 = 1'b0;
   logic sat16, ovr16, sat8, ovr8;

   fir_tap_accumulator_if #(.PROD_WIDTH(PW), .OUT_DATA_WIDTH(OW)) if16 ();
   fir_tap_accumulator_if #(.PROD_WIDTH(PW), .OUT_DATA_WIDTH(OW)) if8 ();

   fir_tap_accumulator #(.NUM_TAPS(4), .PROD_WIDTH(PW), .SHIFT(16)) u16 (
      .clk(clk), .reset_n(reset_n), .bus(if16.slave), .clr(clr16),
      .sat_seen(sat16), .overrun(ovr16));
   fir_tap_accumulator #(.NUM_TAPS(4), .PROD_WIDTH(PW), .SHIFT(8)) u8 (
      .clk(clk), .reset_n(reset_n), .bus(if8.slave), .clr(clr8),
      .sat_seen(sat8), .overrun(ovr8));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   longint q16[$];
   longint q8[$];

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (if16.out_vld && if16.out_rdy) begin
         if (q16.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL out16_unexpected: got %0d expected none", $signed(if16.out_data));
         end else begin
            check("out16", $signed(if16.out_data), q16.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (if8.out_vld && if8.out_rdy) begin
         if (q8.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL out8_unexpected: got %0d expected none", $signed(if8.out_data));
         end else begin
            check("out8", $signed(if8.out_data), q8.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tap(input bit sel8, input logic signed [PW-1:0] v);
      if (sel8) begin
         if8.prod_data = v;
         if8.prod_vld  = 1'b1;
      end else begin
         if16.prod_data = v;
         if16.prod_vld  = 1'b1;
      end
      @(posedge clk);
      #1;
      if8.prod_vld  = 1'b0;
      if16.prod_vld = 1'b0;
   endtask

   task automatic sample(input bit sel8, input logic signed [PW-1:0] a,
                         input logic signed [PW-1:0] b, input logic signed [PW-1:0] c,
                         input logic signed [PW-1:0] d, input int maxgap);
      logic signed [PW-1:0] v[4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 4; i++) begin
         tap(sel8, v[i]);
         if (maxgap > 0 && i < 3) idle($urandom_range(0, maxgap));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      if16.prod_data = '0; if16.prod_vld = 1'b0; if16.out_rdy = 1'b1;
      if8.prod_data  = '0; if8.prod_vld  = 1'b0; if8.out_rdy  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_vld", if16.out_vld, 0);
      check("rst_out_data", $signed(if16.out_data), 0);
      check("rst_sat_seen", sat16, 0);
      check("rst_overrun", ovr16, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // basic sum and two-cycle latency
      q16.push_back(4);
      sample(0, 65536, 65536, 65536, 65536, 0);
      @(negedge clk);
      check("lat_vld_n", if16.out_vld, 0);
      @(negedge clk);
      check("lat_vld_n1", if16.out_vld, 1);
      #1;
      idle(3);
      check("basic_sat_seen", sat16, 0);

      // rounding
      q16.push_back(1);
      sample(0, 32768, 0, 0, 0, 0);
      q16.push_back(0);
      sample(0, -32768, 0, 0, 0, 0);
      q16.push_back(-1);
      sample(0, -32769, 0, 0, 0, 0);
      idle(4);

      // saturation on the SHIFT=8 instance
      q8.push_back(1048575);
      sample(1, 34'sd8589803521, 34'sd8589803521, 34'sd8589803521, 34'sd8589803521, 0);
      q8.push_back(-1048576);
      sample(1, -34'sd8589803521, -34'sd8589803521, -34'sd8589803521, -34'sd8589803521, 0);
      idle(4);
      check("sat8_seen", sat8, 1);
      check("sat16_clean", sat16, 0);

      // overrun: three samples into a stalled two-entry buffer
      if16.out_rdy = 1'b0;
      q16.push_back(1);
      q16.push_back(2);
      sample(0, 65536, 0, 0, 0, 0);
      sample(0, 131072, 0, 0, 0, 0);
      sample(0, 196608, 0, 0, 0, 0);
      idle(4);
      check("ovr_flag", ovr16, 1);
      check("ovr_head_stable", $signed(if16.out_data), 1);
      if16.out_rdy = 1'b1;
      idle(4);
      check("ovr_drained", if16.out_vld, 0);

      // gaps in prod_vld
      q16.push_back(4);
      sample(0, 65536, 65536, 65536, 65536, 5);
      q16.push_back(2);
      sample(0, 100000, -50000, 30000, 70000, 0);
      q16.push_back(2);
      sample(0, 100000, -50000, 30000, 70000, 5);
      idle(4);

      // clr mid-sample, with a product in the same cycle that must be ignored
      tap(0, 458752);
      tap(0, 458752);
      clr16 = 1'b1;
      if16.prod_data = 458752;
      if16.prod_vld  = 1'b1;
      @(posedge clk);
      #1;
      clr16 = 1'b0;
      if16.prod_vld = 1'b0;
      @(negedge clk);
      check("clr_overrun", ovr16, 0);
      check("clr_out_vld", if16.out_vld, 0);
      #1;
      idle(1);
      q16.push_back(4);
      sample(0, 65536, 65536, 65536, 65536, 0);
      idle(4);

      // asynchronous reset mid-sample with a stalled entry in the buffer
      if16.out_rdy = 1'b0;
      sample(0, 327680, 0, 0, 0, 0);
      idle(3);
      check("pre_rst_head", $signed(if16.out_data), 5);
      tap(0, 458752);
      tap(0, 458752);
      reset_n = 1'b0;
      #2;
      check("arst_out_vld", if16.out_vld, 0);
      check("arst_out_data", $signed(if16.out_data), 0);
      check("arst_sat8", sat8, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      if16.out_rdy = 1'b1;
      idle(1);
      q16.push_back(4);
      sample(0, 65536, 65536, 65536, 65536, 0);
      idle(5);

      check("q16_empty", q16.size(), 0);
      check("q8_empty", q8.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
